// File: rtl/serial_compare_ctrl_if.sv
// Request/result bundle between a requesting datapath and the serial comparator.
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CW-1:0]    bits_used;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b,
    input  busy, done, eq, gt, lt, bits_used
  );

  // Comparator side
  modport slave (
    input  start, a, b,
    output busy, done, eq, gt, lt, bits_used
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// MSB-first bit-serial magnitude comparator sequencer.
// One shared 1-bit compare slice is stepped across captured (shadow) operands,
// one bit per clock, reporting eq/gt/lt and the number of bits examined.
module serial_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_compare_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [CW-1:0]    bits_q, bits_d;
  // First-mismatch record, used when the scan continues past a mismatch
  logic             hit_q, hit_d;
  logic             hgt_q, hgt_d;
  logic             hlt_q, hlt_d;
  logic [CW-1:0]    hcnt_q, hcnt_d;

  logic          bit_a;
  logic          bit_b;
  logic          match;
  logic          last_bit;
  logic          early_stop;
  logic [CW-1:0] cnt_inc;

  // Shared 1-bit compare slice on the currently indexed shadow bit
  always_comb begin
    bit_a      = a_sh_q[idx_q];
    bit_b      = b_sh_q[idx_q];
    match      = ~(bit_a ^ bit_b);
    last_bit   = (idx_q == '0);
    early_stop = EARLY_EXIT && !match;
    cnt_inc    = cnt_q + CW'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: termination is checked before any index decrement
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = SCAN;
      SCAN: if (early_stop || last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next-state values
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    eq_d   = eq_q;
    gt_d   = gt_q;
    lt_d   = lt_q;
    bits_d = bits_q;
    hit_d  = hit_q;
    hgt_d  = hgt_q;
    hlt_d  = hlt_q;
    hcnt_d = hcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d = bus.a;
          b_sh_d = bus.b;
          idx_d  = IW'(WIDTH - 1);
          cnt_d  = '0;
          eq_d   = 1'b0;
          gt_d   = 1'b0;
          lt_d   = 1'b0;
          bits_d = '0;
          busy_d = 1'b1;
          hit_d  = 1'b0;
          hgt_d  = 1'b0;
          hlt_d  = 1'b0;
          hcnt_d = '0;
        end
      end
      SCAN: begin
        cnt_d = cnt_inc;
        if (early_stop) begin
          gt_d   = bit_a;
          lt_d   = bit_b;
          bits_d = cnt_inc;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          if (!match && !hit_q) begin
            hit_d  = 1'b1;
            hgt_d  = bit_a;
            hlt_d  = bit_b;
            hcnt_d = cnt_inc;
          end
          if (last_bit) begin
            // An earlier recorded mismatch outranks one found on the last bit
            eq_d   = !(hit_q || !match);
            gt_d   = hit_q ? hgt_q : (!match && bit_a);
            lt_d   = hit_q ? hlt_q : (!match && bit_b);
            bits_d = hit_q ? hcnt_q : (!match ? cnt_inc : CW'(WIDTH));
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Register update; reset clears everything and aborts any scan silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      bits_q <= '0;
      hit_q  <= 1'b0;
      hgt_q  <= 1'b0;
      hlt_q  <= 1'b0;
      hcnt_q <= '0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      eq_q   <= eq_d;
      gt_q   <= gt_d;
      lt_q   <= lt_d;
      bits_q <= bits_d;
      hit_q  <= hit_d;
      hgt_q  <= hgt_d;
      hlt_q  <= hlt_d;
      hcnt_q <= hcnt_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.bits_used = bits_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed + randomized bench for serial_compare_ctrl (WIDTH=8), one instance
// with early exit and one scanning all bits, with a queue-based scoreboard.
module tb_serial_compare_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sel = 1'b0;
  logic         start_v = 1'b0;
  logic [W-1:0] a_v = '0;
  logic [W-1:0] b_v = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   bits;
    int   lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  serial_compare_ctrl_if #(.WIDTH(W)) bus0 ();
  serial_compare_ctrl_if #(.WIDTH(W)) bus1 ();

  assign bus0.start = start_v & ~sel;
  assign bus0.a     = a_v;
  assign bus0.b     = b_v;
  assign bus1.start = start_v & sel;
  assign bus1.a     = a_v;
  assign bus1.b     = b_v;

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic       m_busy, m_done, m_eq, m_gt, m_lt;
  logic [3:0] m_bits;

  always_comb begin
    m_busy = sel ? bus1.busy      : bus0.busy;
    m_done = sel ? bus1.done      : bus0.done;
    m_eq   = sel ? bus1.eq        : bus0.eq;
    m_gt   = sel ? bus1.gt        : bus0.gt;
    m_lt   = sel ? bus1.lt        : bus0.lt;
    m_bits = sel ? bus1.bits_used : bus0.bits_used;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee);
    exp_t r;
    r.eq   = (a == b);
    r.gt   = (a > b);
    r.lt   = (a < b);
    r.bits = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        r.bits = W - i;
        break;
      end
    end
    r.lat = (ee && !r.eq) ? r.bits : W;
    return r;
  endfunction

  task automatic rand_ops(output logic [W-1:0] a, output logic [W-1:0] b);
    int mode;
    mode = $urandom_range(0, 2);
    a = W'($urandom);
    case (mode)
      0: b = a;
      1: b = a ^ (W'(1) << $urandom_range(0, W - 1));
      default: b = W'($urandom);
    endcase
  endtask

  // One compare on instance s; rnd scrambles a/b after capture,
  // inject pulses a second start with other operands during the scan.
  task automatic do_cmp(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit rnd, input bit inject);
    exp_t e;
    int   n;
    bit   seen;
    logic [W-1:0] ra, rb;
    sel = s;
    n = 0;
    while (m_busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_busy) chk("idle_wait_timeout", 1, 0);
    a_v = a;
    b_v = b;
    start_v = 1'b1;
    sb.push_back(model(a, b, s ? 1'b0 : 1'b1));
    @(posedge clk); #1;
    start_v = 1'b0;
    if (rnd) begin
      rand_ops(ra, rb);
      a_v = ra;
      b_v = rb;
    end
    chk("busy_after_start", m_busy, 1);
    chk("res_cleared_after_start", {m_eq, m_gt, m_lt}, 0);
    chk("done_low_after_start", m_done, 0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 2 * W + 4) begin
      @(posedge clk); #1;
      n++;
      start_v = 1'b0;
      if (rnd) begin
        rand_ops(ra, rb);
        a_v = ra;
        b_v = rb;
      end
      if (m_done) begin
        seen = 1'b1;
      end else if (inject && n == 2) begin
        start_v = 1'b1;
        a_v = ~a;
        b_v = a;
      end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("latency", n, e.lat);
      chk("busy_in_done", m_busy, 0);
      chk("eq", m_eq, e.eq);
      chk("gt", m_gt, e.gt);
      chk("lt", m_lt, e.lt);
      chk("bits_used", m_bits, e.bits);
      chk("onehot", $countones({m_eq, m_gt, m_lt}), 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    // Reset state for both instances
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    chk("rst0_outputs", {m_busy, m_done, m_eq, m_gt, m_lt, m_bits}, 0);
    sel = 1'b1;
    chk("rst1_outputs", {m_busy, m_done, m_eq, m_gt, m_lt, m_bits}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Equal operands: full scan, then done lasts one cycle and results hold
    do_cmp(0, 8'hA5, 8'hA5, 0, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", m_done, 0);
    chk("eq_held", m_eq, 1);
    chk("bits_held", m_bits, W);

    // MSB mismatch (early exit), LSB mismatch
    do_cmp(0, 8'h80, 8'h7F, 0, 0);
    do_cmp(0, 8'h12, 8'h13, 0, 0);

    // Full-scan instance
    do_cmp(1, 8'h80, 8'h7F, 0, 0);
    do_cmp(1, 8'h12, 8'h13, 0, 0);
    do_cmp(1, 8'hA5, 8'hA5, 0, 0);
    do_cmp(1, 8'h3C, 8'h5C, 0, 0);

    // Start during scan ignored; then back-to-back starts in the done cycle
    do_cmp(0, 8'hA5, 8'hA5, 0, 1);
    do_cmp(0, 8'h80, 8'h7F, 0, 0);
    do_cmp(0, 8'hF0, 8'hF0, 0, 0);
    do_cmp(0, 8'h01, 8'h02, 0, 0);

    // Reset mid-scan aborts with no done pulse
    sel = 1'b0;
    a_v = 8'hA5;
    b_v = 8'hA5;
    start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_abort", m_busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_outputs", {m_busy, m_done, m_eq, m_gt, m_lt, m_bits}, 0);
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", m_done, 0);
    end
    do_cmp(0, 8'd3, 8'd5, 0, 0);

    // Randomized compares with operands scrambled after capture
    for (int i = 0; i < 200; i++) begin
      rand_ops(ra, rb);
      do_cmp(0, ra, rb, 1, 0);
    end
    for (int i = 0; i < 30; i++) begin
      rand_ops(ra, rb);
      do_cmp(1, ra, rb, 1, 0);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
